// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/response handshake bundle for the bit-serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             busy;

    modport master (
        output start_valid, op_a, op_b, res_ready,
        input  start_ready, res_valid, res_sum, res_cout, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, res_ready,
        output start_ready, res_valid, res_sum, res_cout, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full-adder slice over WIDTH cycles.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ps_q, ps_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic             hs, hc0, s, hc1, cy;

    // Full-adder slice: two half adders plus an OR for the carry.
    half_adder u_ha0 (.a_i(sa_q[0]), .b_i(sb_q[0]), .s_o(hs), .c_o(hc0));
    half_adder u_ha1 (.a_i(hs),      .b_i(c_q),     .s_o(s),  .c_o(hc1));
    assign cy = hc0 | hc1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (bus.start_valid) begin
                sa_d    = bus.op_a;
                sb_d    = bus.op_b;
                ps_d    = '0;
                c_d     = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                ps_d = {s, ps_q[WIDTH-1:1]};
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                c_d  = cy;
                // Counter holds on the last bit so it never wraps.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {s, ps_q[WIDTH-1:1]};
                    cout_d  = cy;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = bus.res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.res_sum     = sum_q;
    assign bus.res_cout    = cout_q;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit add slice over WIDTH cycles to produce a WIDTH-bit sum plus carry-out. The slice is a full adder built from two instances of the team's existing half-adder module and an OR gate, with a registered carry. Operands enter through a valid/ready request port and results leave through a valid/ready response port. The block is the area-minimal adder option for lab designs where latency is not critical.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock; the only clock domain.
- rst_n  input  1  synchronous, active-low reset.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  block can accept a request (high only in IDLE).
- op_a  input  WIDTH  operand A; sampled on the request handshake.
- op_b  input  WIDTH  operand B; sampled on the request handshake.
- res_valid  output  1  res_sum and res_cout hold a completed result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH  sum modulo 2^WIDTH.
- res_cout  output  1  carry-out of the MSB.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE
  - start_ready=1.
  - On start_valid=1 at a clock edge:
    - load op_a and op_b into shift registers sa and sb;
    - clear the carry flop c and the partial-sum shift register ps;
    - set bit counter cnt=0;
    - go to RUN.
- RUN, every cycle:
  - slice computes s = sa[0]^sb[0]^c;
  - carry next = (sa[0]&sb[0]) | ((sa[0]^sb[0])&c);
  - ps shifts right with s entering at bit WIDTH-1;
  - sa and sb shift right; cnt increments.
  - When cnt==WIDTH-1 (last bit):
    - load res_sum from the final shifted ps value;
    - load res_cout from the final carry;
    - go to DONE.
  - The counter is $clog2(WIDTH) bits wide and never wraps, because it exits at WIDTH-1.
- DONE
  - res_valid=1.
  - On res_ready=1 at an edge, go to IDLE.
  - res_sum and res_cout stay stable while res_valid=1 and res_ready=0.
- Combinational outputs:
  - start_ready = (state==IDLE);
  - res_valid = (state==DONE);
  - busy = (state!=IDLE).
- res_sum and res_cout are registered. They hold the last completed result until the next completion or reset, and change only on the RUN→DONE edge.
- start_valid in RUN or DONE is ignored; the operands are not re-sampled.
- Reset has priority over every transition. With rst_n=0 at an edge:
  - state returns to IDLE;
  - res_sum=0, res_cout=0, c=0, cnt=0, sa=sb=ps=0.
  - Any in-flight operation is discarded with no result.
- Reset outputs (cycle after the reset edge): start_ready=1, res_valid=0, busy=0, res_sum=0, res_cout=0.

## Timing
- Request handshake at edge E0 gives RUN during the cycles after edges E0..E(WIDTH-1).
- DONE is entered at edge E(WIDTH), so res_valid rises in the cycle after E(WIDTH): a latency of WIDTH cycles.
- A response handshake at edge E(WIDTH+1) (res_ready held 1) returns to IDLE. start_ready is high after E(WIDTH+1), and the next request can be accepted at E(WIDTH+2).
- Maximum throughput is one add per WIDTH+2 cycles. There is no same-edge result-accept and restart.
- No combinational path from any input to any output except the state-derived handshake signals.

## Test plan
- WIDTH=8, op_a=8'h3C, op_b=8'h5A, res_ready=1 -> res_sum=8'h96, res_cout=0; res_valid rises exactly 8 cycles after the accept edge.
- op_a=8'hFF, op_b=8'h01 -> res_sum=8'h00, res_cout=1.
- op_a=8'hFF, op_b=8'hFF -> res_sum=8'hFE, res_cout=1.
- Hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1 and res_sum/res_cout stay constant. Raising res_ready gives IDLE next cycle with start_ready=1.
- Assert start_valid with new operands (8'h11, 8'h22) throughout RUN -> start_ready=0 and the first result is unaffected. The second request is accepted only after returning to IDLE and yields 8'h33.
- Drive rst_n=0 for 1 cycle at RUN cycle 3 -> next cycle is IDLE with busy=0, res_valid=0, res_sum=0, res_cout=0, and no result is produced. A following add of 8'h01+8'h01 gives 8'h02.
- Back-to-back adds with start_valid=1 and res_ready=1 held constantly -> accept edges exactly 10 cycles apart.
